sram_req_ctrl: RTL and testbench

//  Request-side controller that sits directly upstream of the SRAM wrapper.

---
 rtl/sram_req_ctrl_if.sv | 24 ++
 rtl/sram_req_ctrl.sv | 100 ++++++++++
 tb/tb_sram_req_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_ctrl_if.sv
// Request/response channel between the core/bus and the SRAM request controller.
// master = requester side, slave = controller side.
interface sram_req_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_we;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_is_write;

   modport master (
      output req_valid, req_addr, req_we, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_is_write
   );

   modport slave (
      input  req_valid, req_addr, req_we, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_is_write
   );
endinterface

// File: rtl/sram_req_ctrl.sv
// One-at-a-time word access controller driving the SRAM wrapper port.
// Latency WAIT_CYCLES+2 from request handshake to resp_valid; requests stall (never drop) until the response is taken.
module sram_req_ctrl #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   sram_req_ctrl_if.slave     bus,
   output logic               io_sram_en,
   output logic               io_sram_we,
   output logic [19:0]        io_sram_addr,
   output logic [31:0]        io_sram_din,
   output logic [3:0]         io_sram_wmask,
   input  logic [31:0]        io_sram_dout
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   localparam logic [4:0] WAIT5 = 5'(WAIT_CYCLES);

   generate
      if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
         $error("sram_req_ctrl: WAIT_CYCLES must be in 1..15");
      end
   endgenerate

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [4:0]  cnt_inc;
   logic        resp_valid_q;
   logic [31:0] resp_rdata_q;
   logic        resp_is_write_q;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^{bus.req_addr[31:22], bus.req_addr[1:0]};

   // Widened so cnt+1 never wraps when WAIT_CYCLES is 15.
   assign cnt_inc = {1'b0, cnt} + 5'd1;

   assign bus.req_ready     = (state == IDLE);
   assign bus.resp_valid    = resp_valid_q;
   assign bus.resp_rdata    = resp_rdata_q;
   assign bus.resp_is_write = resp_is_write_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= 4'd0;
         resp_valid_q    <= 1'b0;
         resp_rdata_q    <= 32'd0;
         resp_is_write_q <= 1'b0;
         io_sram_en      <= 1'b0;
         io_sram_we      <= 1'b0;
         io_sram_addr    <= 20'd0;
         io_sram_din     <= 32'd0;
         io_sram_wmask   <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  io_sram_addr  <= bus.req_addr[21:2];
                  io_sram_we    <= bus.req_we;
                  io_sram_din   <= bus.req_wdata;
                  io_sram_wmask <= bus.req_wstrb;
                  io_sram_en    <= 1'b1;
                  cnt           <= 4'd0;
                  state         <= ACCESS;
               end
            end
            ACCESS: begin
               // Final cycle has en low; read data has been stable since the first en edge.
               if (cnt == WAIT5[3:0]) begin
                  resp_rdata_q    <= io_sram_we ? 32'd0 : io_sram_dout;
                  resp_is_write_q <= io_sram_we;
                  resp_valid_q    <= 1'b1;
                  io_sram_we      <= 1'b0;
                  state           <= RESP;
               end else begin
                  cnt        <= cnt_inc[3:0];
                  io_sram_en <= (cnt_inc < WAIT5);
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               io_sram_en <= 1'b0;
               io_sram_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench: two controller instances (WAIT_CYCLES 1 and 3), each with a behavioural SRAM.
// sel picks which instance receives stimulus and is observed.
module tb_sram_req_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        sel;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_we;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_ready;

   int checks = 0;
   int errors = 0;
   int en_cnt = 0;
   int we_cnt = 0;

   sram_req_ctrl_if if1 ();
   sram_req_ctrl_if if3 ();

   assign if1.req_valid  = req_valid & ~sel;
   assign if1.req_addr   = req_addr;
   assign if1.req_we     = req_we;
   assign if1.req_wdata  = req_wdata;
   assign if1.req_wstrb  = req_wstrb;
   assign if1.resp_ready = resp_ready & ~sel;
   assign if3.req_valid  = req_valid & sel;
   assign if3.req_addr   = req_addr;
   assign if3.req_we     = req_we;
   assign if3.req_wdata  = req_wdata;
   assign if3.req_wstrb  = req_wstrb;
   assign if3.resp_ready = resp_ready & sel;

   logic        en1, we1, en3, we3;
   logic [19:0] addr1, addr3;
   logic [31:0] din1, din3, dout1, dout3;
   logic [3:0]  wm1, wm3;

   sram_req_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(if1.slave),
      .io_sram_en(en1), .io_sram_we(we1), .io_sram_addr(addr1),
      .io_sram_din(din1), .io_sram_wmask(wm1), .io_sram_dout(dout1)
   );

   sram_req_ctrl #(.WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .bus(if3.slave),
      .io_sram_en(en3), .io_sram_we(we3), .io_sram_addr(addr3),
      .io_sram_din(din3), .io_sram_wmask(wm3), .io_sram_dout(dout3)
   );

   // Behavioural SRAMs: address registered on en, read data valid the following cycle.
   logic [31:0] mem1 [0:255];
   logic [31:0] mem3 [0:255];

   always @(posedge clk) begin
      if (en1) begin
         if (we1)
            for (int b = 0; b < 4; b++)
               if (wm1[b]) mem1[addr1[7:0]][b*8 +: 8] <= din1[b*8 +: 8];
         dout1 <= mem1[addr1[7:0]];
      end
      if (en3) begin
         if (we3)
            for (int b = 0; b < 4; b++)
               if (wm3[b]) mem3[addr3[7:0]][b*8 +: 8] <= din3[b*8 +: 8];
         dout3 <= mem3[addr3[7:0]];
      end
   end

   logic        obs_req_ready, obs_resp_valid, obs_is_write, obs_en, obs_we;
   logic [31:0] obs_rdata, obs_din;
   logic [19:0] obs_addr;
   logic [3:0]  obs_wm;

   always_comb begin
      obs_req_ready  = sel ? if3.req_ready     : if1.req_ready;
      obs_resp_valid = sel ? if3.resp_valid    : if1.resp_valid;
      obs_is_write   = sel ? if3.resp_is_write : if1.resp_is_write;
      obs_rdata      = sel ? if3.resp_rdata    : if1.resp_rdata;
      obs_en         = sel ? en3   : en1;
      obs_we         = sel ? we3   : we1;
      obs_addr       = sel ? addr3 : addr1;
      obs_din        = sel ? din3  : din1;
      obs_wm         = sel ? wm3   : wm1;
   end

   always @(negedge clk) begin
      if (obs_en) en_cnt++;
      if (obs_en && obs_we) we_cnt++;
   end

   task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
      int n;
      req_addr = a; req_we = w; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
      n = 0;
      while (obs_req_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL send_timeout: req_ready=%b required 1", obs_req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Returns the cycle index (handshake cycle = 0) at which resp_valid is seen.
   task automatic wait_resp(output int n);
      n = 1;
      while (obs_resp_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL resp_timeout: resp_valid=%b required 1", obs_resp_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         checks++;
         if ({obs_req_ready, obs_resp_valid, obs_is_write, obs_en, obs_we} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl[%0d]: got %b required 10000", s,
                     {obs_req_ready, obs_resp_valid, obs_is_write, obs_en, obs_we});
         end
         checks++;
         if ({obs_rdata, obs_addr, obs_din, obs_wm} !== 88'd0) begin
            errors++;
            $display("FAIL reset_data[%0d]: rdata=%h addr=%h din=%h wm=%h required all 0", s,
                     obs_rdata, obs_addr, obs_din, obs_wm);
         end
      end
      sel = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_write_w1();
      int n, c_en, c_we;
      sel = 1'b0; resp_ready = 1'b1;
      c_en = en_cnt; c_we = we_cnt;
      send(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
      checks++;
      if ({obs_en, obs_we, obs_addr, obs_din, obs_wm} !== {2'b11, 20'h4, 32'hDEAD_BEEF, 4'hF}) begin
         errors++;
         $display("FAIL w1_sram_port: en=%b we=%b addr=%h din=%h wm=%h required 1 1 00004 deadbeef f",
                  obs_en, obs_we, obs_addr, obs_din, obs_wm);
      end
      wait_resp(n);
      checks++;
      if (n !== 3) begin errors++; $display("FAIL w1_latency: got %0d required 3", n); end
      checks++;
      if ({obs_is_write, obs_rdata} !== {1'b1, 32'd0}) begin
         errors++;
         $display("FAIL w1_ack: is_write=%b rdata=%h required 1 00000000", obs_is_write, obs_rdata);
      end
      checks++;
      if (en_cnt - c_en !== 1 || we_cnt - c_we !== 1) begin
         errors++;
         $display("FAIL w1_en_cycles: en=%0d we=%0d required 1 1", en_cnt - c_en, we_cnt - c_we);
      end
      @(posedge clk); #1;
      checks++;
      if ({obs_resp_valid, obs_req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL w1_consume: resp_valid=%b req_ready=%b required 0 1", obs_resp_valid, obs_req_ready);
      end
   endtask

   task automatic test_read_w1();
      int n;
      sel = 1'b0; resp_ready = 1'b1;
      send(32'h0000_0010, 1'b0, 32'h0, 4'h0);
      checks++;
      if ({obs_en, obs_we} !== 2'b10) begin
         errors++; $display("FAIL r1_port: en=%b we=%b required 1 0", obs_en, obs_we);
      end
      wait_resp(n);
      checks++;
      if (n !== 3) begin errors++; $display("FAIL r1_latency: got %0d required 3", n); end
      checks++;
      if ({obs_is_write, obs_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL r1_data: is_write=%b rdata=%h required 0 deadbeef", obs_is_write, obs_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_zero_strb();
      int n;
      sel = 1'b0; resp_ready = 1'b1;
      send(32'h0000_0010, 1'b1, 32'h0, 4'h0);
      wait_resp(n);
      checks++;
      if ({obs_is_write, n} !== {1'b1, 32'd3}) begin
         errors++; $display("FAIL zstrb_ack: is_write=%b latency=%0d required 1 3", obs_is_write, n);
      end
      @(posedge clk); #1;
      send(32'h0000_0010, 1'b0, 32'h0, 4'h0);
      wait_resp(n);
      checks++;
      if (obs_rdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL zstrb_data: got %h required deadbeef", obs_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_partial_w3();
      int n, c_en, c_we;
      sel = 1'b1; resp_ready = 1'b1;
      send(32'h0000_0020, 1'b1, 32'hAAAA_AAAA, 4'hF);
      wait_resp(n);
      @(posedge clk); #1;
      c_en = en_cnt; c_we = we_cnt;
      send(32'h0000_0020, 1'b1, 32'h1122_3344, 4'h3);
      wait_resp(n);
      checks++;
      if (n !== 5) begin errors++; $display("FAIL w3_wr_latency: got %0d required 5", n); end
      checks++;
      if (en_cnt - c_en !== 3 || we_cnt - c_we !== 3) begin
         errors++;
         $display("FAIL w3_wr_en_cycles: en=%0d we=%0d required 3 3", en_cnt - c_en, we_cnt - c_we);
      end
      @(posedge clk); #1;
      c_en = en_cnt;
      send(32'h0000_0020, 1'b0, 32'h0, 4'h0);
      wait_resp(n);
      checks++;
      if (obs_rdata !== 32'hAAAA_3344 || n !== 5) begin
         errors++; $display("FAIL w3_rd: rdata=%h latency=%0d required aaaa3344 5", obs_rdata, n);
      end
      checks++;
      if (en_cnt - c_en !== 3) begin
         errors++; $display("FAIL w3_rd_en_cycles: got %0d required 3", en_cnt - c_en);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_pressure();
      int n, c_en;
      sel = 1'b1; resp_ready = 1'b0;
      send(32'h0000_0020, 1'b0, 32'h0, 4'h0);
      wait_resp(n);
      req_addr = 32'h0000_0024; req_we = 1'b1; req_wdata = 32'h0BAD_CAFE; req_wstrb = 4'hF;
      req_valid = 1'b1;
      c_en = en_cnt;
      repeat (5) begin
         @(posedge clk); #1;
         checks++;
         if ({obs_resp_valid, obs_req_ready, obs_rdata} !== {2'b10, 32'hAAAA_3344}) begin
            errors++;
            $display("FAIL bp_hold: resp_valid=%b req_ready=%b rdata=%h required 1 0 aaaa3344",
                     obs_resp_valid, obs_req_ready, obs_rdata);
         end
      end
      checks++;
      if (en_cnt !== c_en) begin
         errors++; $display("FAIL bp_no_access: en cycles=%0d required 0", en_cnt - c_en);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({obs_resp_valid, obs_req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL bp_release: resp_valid=%b req_ready=%b required 0 1", obs_resp_valid, obs_req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if ({obs_en, obs_we, obs_addr} !== {2'b11, 20'h9}) begin
         errors++;
         $display("FAIL bp_second: en=%b we=%b addr=%h required 1 1 00009", obs_en, obs_we, obs_addr);
      end
      wait_resp(n);
      checks++;
      if ({obs_is_write, obs_rdata, n} !== {1'b1, 32'd0, 32'd5}) begin
         errors++;
         $display("FAIL bp_second_ack: is_write=%b rdata=%h latency=%0d required 1 00000000 5",
                  obs_is_write, obs_rdata, n);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_access();
      int n;
      sel = 1'b1; resp_ready = 1'b1;
      send(32'h0000_0030, 1'b1, 32'hCAFE_F00D, 4'hF);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({obs_en, obs_we, obs_resp_valid, obs_req_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL rst_abort: en=%b we=%b resp_valid=%b req_ready=%b required 0 0 0 1",
                  obs_en, obs_we, obs_resp_valid, obs_req_ready);
      end
      rst = 1'b0;
      send(32'h0000_0020, 1'b0, 32'h0, 4'h0);
      wait_resp(n);
      checks++;
      if ({obs_is_write, obs_rdata, n} !== {1'b0, 32'hAAAA_3344, 32'd5}) begin
         errors++;
         $display("FAIL rst_recover: is_write=%b rdata=%h latency=%0d required 0 aaaa3344 5",
                  obs_is_write, obs_rdata, n);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_alias();
      int n;
      sel = 1'b0; resp_ready = 1'b1;
      send(32'hFFC0_0007, 1'b1, 32'h5A5A_1234, 4'hF);
      wait_resp(n);
      @(posedge clk); #1;
      send(32'hFFC0_0007, 1'b0, 32'h0, 4'h0);
      checks++;
      if (obs_addr !== 20'h00001) begin
         errors++; $display("FAIL alias_addr: got %h required 00001", obs_addr);
      end
      wait_resp(n);
      checks++;
      if (obs_rdata !== 32'h5A5A_1234) begin
         errors++; $display("FAIL alias_data: got %h required 5a5a1234", obs_rdata);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
      req_wdata = '0; req_wstrb = '0; resp_ready = 1'b1;
      test_reset();
      test_write_w1();
      test_read_w1();
      test_zero_strb();
      test_partial_w3();
      test_back_pressure();
      test_reset_mid_access();
      test_alias();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
